// File: rtl/inv_matriz_loader.sv
// Streams 16 matrix elements into the packed inverter operand, runs the inverter, and holds the inverse for a consumer.
// Latency: start rises 1 cycle after the last beat; res_valid rises 1 cycle after done is sampled.
// Backpressure: in_ready is low outside LOAD; the result is held until res_ready.
module inv_matriz_loader #(
  parameter int DATA_W = 32,
  parameter int N_ELEM = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [DATA_W*N_ELEM-1:0]   A_out,
  output logic                       start,
  input  logic                       inv_done,
  input  logic [DATA_W*N_ELEM-1:0]   x_in,
  output logic [DATA_W*N_ELEM-1:0]   res_data,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       frame_err
);

  localparam int CNT_W = $clog2(N_ELEM);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ELEM - 1);

  typedef enum logic [1:0] {S_LOAD, S_START, S_RESULT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             first_cyc;
  logic             beat;

  assign beat = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  // A done seen in the first START cycle may be left over from the previous run.
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:   if (beat && in_last && cnt == LAST_IDX) state_nxt = S_START;
      S_START:  if (!first_cyc && inv_done)              state_nxt = S_RESULT;
      S_RESULT: if (res_ready)                           state_nxt = S_LOAD;
      default:                                           state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    start     = 1'b0;
    res_valid = 1'b0;
    case (state)
      S_LOAD:   in_ready  = !rst;
      S_START:  start     = 1'b1;
      S_RESULT: res_valid = 1'b1;
      default:  in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      A_out     <= '0;
      res_data  <= '0;
      frame_err <= 1'b0;
      first_cyc <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      first_cyc <= 1'b0;
      if (state == S_LOAD && beat) begin
        if (in_last && cnt != LAST_IDX) begin
          cnt       <= '0;
          frame_err <= 1'b1;
        end else begin
          A_out[cnt*DATA_W +: DATA_W] <= in_data;
          if (cnt == LAST_IDX) begin
            cnt       <= '0;
            frame_err <= !in_last;
            first_cyc <= in_last;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end
      if (state == S_START && !first_cyc && inv_done)
        res_data <= x_in;
    end
  end

endmodule
